boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 4'h8, the first boot-memory word address written.
REQ-002 The block SHALL have parameter NUM_WORDS, default 8, the number of 16-bit words loaded per session; BASE_ADDR+NUM_WORDS-1 <= 15.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, the maximum idle romclk cycles allowed between bytes.
REQ-004 romclk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a load session.
REQ-007 rx_data  input  8  byte from the serial receiver.
REQ-008 rx_valid  input  1  rx_data is valid.
REQ-009 rx_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_cs  output  1  boot memory chip select.
REQ-011 mem_we  output  1  boot memory write enable.
REQ-012 mem_addr  output  4  boot memory word address.
REQ-013 mem_din  output  16  boot memory write data.
REQ-014 busy  output  1  session in progress.
REQ-015 done  output  1  session completed; sticky until next start or reset.
REQ-016 err  output  1  session failed (timeout or checksum); sticky until next start or reset.

Function
REQ-017 The FSM SHALL have states IDLE, HI, LO, WRITE, CHK_HI, CHK_LO, FIN; CHK_* exist only per REQ-031.
REQ-018 IDLE or FIN with start=1 SHALL go to HI, clear done/err, load word index to 0, set busy; start in any other state SHALL be ignored.
REQ-019 rx_ready SHALL be 1 only in HI, LO, CHK_HI, CHK_LO; a byte is accepted on a cycle with rx_valid & rx_ready.
REQ-020 An accepted byte in HI SHALL become word bits [15:8] and move to LO; in LO it SHALL become bits [7:0] and move to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with mem_cs=1, mem_we=1, mem_addr=BASE_ADDR+index, mem_din=assembled word.
REQ-022 mem_addr and mem_din SHALL be driven stable from entry to LO through the cycle after WRITE; mem_cs/mem_we SHALL be 0 outside WRITE.
REQ-023 After WRITE, index<NUM_WORDS-1 SHALL increment index and go to HI; otherwise go to FIN (or CHK_HI per REQ-031).
REQ-024 Index arithmetic SHALL be 4-bit with no wrap past BASE_ADDR+NUM_WORDS-1; no write outside that range SHALL ever occur.
REQ-025 FIN SHALL set done=1, busy=0 and return nothing to memory; FIN behaves as IDLE for start.
REQ-026 In HI/LO/CHK_HI/CHK_LO a 16-bit idle counter SHALL count cycles without an accepted byte and reset on each accepted byte; reaching TIMEOUT SHALL set err=1, done=1, busy=0, state FIN.
REQ-027 Latency: first byte accepted to WRITE = 1 cycle after second byte; 8-word session = 16 byte acceptances + 8 WRITE cycles minimum.
REQ-028 Words already written before a timeout or reset SHALL remain in memory; the loader does no rollback.

Reset
REQ-029 rst=1 SHALL force state IDLE, index 0, idle counter 0, and outputs rx_ready=0, mem_cs=0, mem_we=0, mem_addr=BASE_ADDR, mem_din=0, busy=0, done=0, err=0, immediately, including mid-session.

Configuration
REQ-030 Macro BOOT_LOADER_CHECKSUM_EN SHALL select checksum support.
REQ-031 With BOOT_LOADER_CHECKSUM_EN defined: after the last WRITE, the FSM SHALL go CHK_HI, CHK_LO, receive a 16-bit checksum (high byte first), then FIN with err=1 if it differs from the mod-2^16 sum of all loaded words; without it: last WRITE goes to FIN, no sum register exists, err arises only from timeout.

Structure
REQ-032 Package boot_loader_pkg SHALL hold the state enum, default BASE_ADDR/NUM_WORDS/TIMEOUT constants and the idle-counter width.
REQ-033 Sub-module boot_word_assembler SHALL hold the HI/LO byte packing register and the optional running sum.

Verification
REQ-034 start, bytes F2 00 40 00 -> writes 16'hF200 at addr 8 then 16'h4000 at addr 9, one WRITE cycle each.
REQ-035 Full 16 bytes, rx_valid always 1 -> 8 writes at 8..F, done=1, err=0, busy=0, no write to addr 0..7.
REQ-036 Stop bytes after 3 bytes, TIMEOUT=15 -> err=1, done=1 after 15 idle cycles; addr 8 written, addr 9 not.
REQ-037 rst pulse while in LO -> all outputs at reset values same cycle; next start restarts at addr 8.
REQ-038 start asserted during HI -> ignored; index and captured bytes unchanged.
REQ-039 CHECKSUM_EN, words 0001..0008, checksum 0024 -> err=0; checksum 0025 -> err=1, done=1.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared state encoding and default parameters for the boot loader.
// BOOT_LOADER_CHECKSUM_EN adds the checksum reception states.
package boot_loader_pkg;

  localparam logic [3:0]  BASE_ADDR_DEF = 4'h8;
  localparam int unsigned NUM_WORDS_DEF = 8;
  localparam int unsigned TIMEOUT_DEF   = 1023;
  localparam int unsigned IDLE_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WRITE,
    FIN
`ifdef BOOT_LOADER_CHECKSUM_EN
    , CHK_HI
    , CHK_LO
`endif
  } state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs received bytes into the 16-bit boot word; with BOOT_LOADER_CHECKSUM_EN
// also keeps the running word sum and the received checksum high byte.
module boot_word_assembler
  import boot_loader_pkg::*;
(
  input  logic        romclk,
  input  logic        rst,
  input  logic        hi_ld_i,
  input  logic        lo_ld_i,
  input  logic [7:0]  byte_i,
`ifdef BOOT_LOADER_CHECKSUM_EN
  input  logic        clr_i,
  input  logic        add_i,
  input  logic        chk_hi_ld_i,
  output logic        chk_ok_o,
`endif
  output logic [15:0] word_o
);

  logic [7:0] hi_q;
  logic [7:0] lo_q;

  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_ld_i) hi_q <= byte_i;
      if (lo_ld_i) lo_q <= byte_i;
    end
  end

  assign word_o = {hi_q, lo_q};

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic [7:0]  chk_hi_q;

  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      chk_hi_q <= '0;
    end else begin
      if (clr_i)      sum_q <= '0;
      else if (add_i) sum_q <= sum_q + {hi_q, lo_q};
      if (chk_hi_ld_i) chk_hi_q <= byte_i;
    end
  end

  // Low checksum byte is compared as it is accepted.
  assign chk_ok_o = ({chk_hi_q, byte_i} == sum_q);
`endif

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: receives NUM_WORDS big-endian words and writes them to
// boot memory from BASE_ADDR. BOOT_LOADER_CHECKSUM_EN enables a trailing checksum.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [3:0]  BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        romclk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [3:0]  mem_addr,
  output logic [15:0] mem_din,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0]        LAST_IDX = 4'(NUM_WORDS - 1);
  localparam logic [IDLE_W-1:0] TO_LAST  = IDLE_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [3:0]        index_q, index_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [3:0]        addr_q, addr_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              wait_st, accept;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic chk_ok;
  assign wait_st = (state_q == HI) || (state_q == LO) ||
                   (state_q == CHK_HI) || (state_q == CHK_LO);
`else
  assign wait_st = (state_q == HI) || (state_q == LO);
`endif
  assign accept = wait_st && rx_valid;

  boot_word_assembler u_asm (
    .romclk      (romclk),
    .rst         (rst),
    .hi_ld_i     (accept && (state_q == HI)),
    .lo_ld_i     (accept && (state_q == LO)),
    .byte_i      (rx_data),
`ifdef BOOT_LOADER_CHECKSUM_EN
    .clr_i       (start && ((state_q == IDLE) || (state_q == FIN))),
    .add_i       (state_q == WRITE),
    .chk_hi_ld_i (accept && (state_q == CHK_HI)),
    .chk_ok_o    (chk_ok),
`endif
    .word_o      (mem_din)
  );

  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      idle_q  <= '0;
      addr_q  <= BASE_ADDR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      idle_q  <= idle_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    idle_d  = '0;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, FIN: if (start) begin
        state_d = HI;
        index_d = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      HI: if (accept) begin
        // Address is latched here so it stays put until the next word's high byte.
        addr_d  = BASE_ADDR + index_q;
        state_d = LO;
      end
      LO: if (accept) state_d = WRITE;
      WRITE: begin
        if (index_q < LAST_IDX) begin
          index_d = index_q + 4'd1;
          state_d = HI;
        end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          state_d = CHK_HI;
`else
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHK_HI: if (accept) state_d = CHK_LO;
      CHK_LO: if (accept) begin
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = !chk_ok;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (wait_st && !accept) begin
      if (idle_q == TO_LAST) begin
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  assign rx_ready = wait_st;
  assign mem_cs   = (state_q == WRITE);
  assign mem_we   = (state_q == WRITE);
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued by the
// stimulus and popped by a monitor thread whenever the DUT writes.
module tb_boot_loader;

  localparam logic [3:0]  BASE = 4'h8;
  localparam int unsigned NW   = 8;
  localparam int unsigned TO   = 15;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam int unsigned LAT  = 26;
`else
  localparam int unsigned LAT  = 24;
`endif

  logic        romclk, rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_cs, mem_we, busy, done, err;
  logic [3:0]  mem_addr;
  logic [15:0] mem_din;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  boot_loader #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .TIMEOUT(TO)) dut (
    .romclk   (romclk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 romclk = ~romclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [3:0]  la;
    logic [15:0] ld;
    bit          after;
    wr_t         e;
    after = 1'b0;
    la    = '0;
    ld    = '0;
    forever begin
      @(negedge romclk);
      if (after) begin
        check("hold_addr", mem_addr, la);
        check("hold_din", mem_din, ld);
        after = 1'b0;
      end
      if (mem_cs || mem_we) begin
        check("cs_we_pair", {mem_cs, mem_we}, 2'b11);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required none", mem_addr, mem_din);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_din, e.data);
          la    = mem_addr;
          ld    = mem_din;
          after = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle_counter();
    forever begin
      @(posedge romclk);
      cyc++;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    repeat (gap) @(negedge romclk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge romclk);
      n++;
    end
    if (!rx_ready) check("accept_bound", rx_ready, 1'b1);
    @(negedge romclk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge romclk);
    start = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1'b0);
    check({tag, "_mem_cs"}, mem_cs, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, BASE);
    check({tag, "_mem_din"}, mem_din, 16'h0000);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  task automatic session(input logic [15:0] w [NW], input int unsigned max_gap,
                         input bit bad_sum, input bit poke, input bit meas);
    logic [15:0] sum;
    int unsigned t0, n;
    bit          exp_err;
    sum     = '0;
    exp_err = 1'b0;
    pulse_start();
    t0 = cyc;
    check("busy_after_start", busy, 1'b1);
    check("done_cleared", done, 1'b0);
    check("err_cleared", err, 1'b0);
    for (int unsigned k = 0; k < NW; k++) begin
      sum = sum + w[k];
      exp_q.push_back('{addr: BASE + 4'(k), data: w[k]});
      if (poke && k == 1) begin
        @(negedge romclk);
        pulse_start();
        check("start_ignored_busy", busy, 1'b1);
        check("start_ignored_done", done, 1'b0);
      end
      send_byte(w[k][15:8], meas ? 0 : $urandom_range(0, max_gap));
      send_byte(w[k][7:0], meas ? 0 : $urandom_range(0, max_gap));
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    exp_err = bad_sum;
    send_byte(sum[15:8], 0);
    send_byte(sum[7:0] ^ {7'd0, bad_sum}, 0);
`endif
    n = 0;
    while (!done && n < 40) begin
      @(negedge romclk);
      n++;
    end
    check("sess_done", done, 1'b1);
    check("sess_err", err, exp_err);
    check("sess_busy", busy, 1'b0);
    check("writes_drained", exp_q.size(), 0);
    if (meas) check("latency", cyc - t0, LAT);
  endtask

  initial begin
    logic [15:0] w [NW];
    romclk   = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    fork
      monitor();
      cycle_counter();
      begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
      end
    join_none
    #1;
    reset_vals("por");
    @(negedge romclk);
    @(negedge romclk);
    rst = 1'b0;

    // F2 00 40 00 first, rx_valid held high, latency measured
    w[0] = 16'hF200;
    w[1] = 16'h4000;
    for (int unsigned k = 2; k < NW; k++) w[k] = 16'($urandom);
    session(w, 0, 1'b0, 1'b0, 1'b1);

    for (int unsigned k = 0; k < NW; k++) w[k] = 16'(k + 1);
    session(w, 2, 1'b0, 1'b0, 1'b0);
    session(w, 2, 1'b1, 1'b0, 1'b0);

    for (int unsigned k = 0; k < NW; k++) w[k] = 16'($urandom);
    session(w, 4, 1'b0, 1'b1, 1'b0);

    // Timeout after three bytes: only the first word lands
    pulse_start();
    exp_q.push_back('{addr: BASE, data: 16'hF200});
    send_byte(8'hF2, 0);
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    repeat (TO - 1) @(negedge romclk);
    check("no_early_timeout", err, 1'b0);
    @(negedge romclk);
    check("timeout_err", err, 1'b1);
    check("timeout_done", done, 1'b1);
    check("timeout_busy", busy, 1'b0);
    check("timeout_writes", exp_q.size(), 0);

    // Reset while waiting for a low byte
    pulse_start();
    send_byte(8'hA5, 0);
    check("in_lo_ready", rx_ready, 1'b1);
    rst = 1'b1;
    #1;
    reset_vals("mid_rst");
    @(negedge romclk);
    rst = 1'b0;

    for (int r = 0; r < 3; r++) begin
      for (int unsigned k = 0; k < NW; k++) w[k] = 16'($urandom);
      session(w, 5, 1'b0, (r == 1), 1'b0);
    end

    repeat (3) @(negedge romclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
